// File: rtl/regfile_access_ctrl.sv
// Valid/ready sequencer that drives strobe-captured register file ports.
// Define REGFILE_CTRL_PERF_EN to add read/write handshake counters.
module regfile_access_ctrl #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RfLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef REGFILE_CTRL_PERF_EN
  output logic [31:0]          rd_count_o,
  output logic [31:0]          wr_count_o,
`endif
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  output logic                 opnd_valid_o,
  input  logic                 opnd_ready_i,
  output logic [DataWidth-1:0] rs1_data_o,
  output logic [DataWidth-1:0] rs2_data_o,
  input  logic                 wb_valid_i,
  output logic                 wb_ready_o,
  input  logic [4:0]           wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 rf_req_ra_o,
  output logic                 rf_req_rb_o,
  output logic                 rf_req_w_o,
  output logic [4:0]           rf_raddr_a_o,
  output logic [4:0]           rf_raddr_b_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE,
    RD_SETUP, RD_PULSE, RD_WAIT, RESP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q;
  logic       op_hs, wb_hs;
  logic       rd_a_en, rd_b_en;
  logic       wait_done;

  assign rd_a_en   = |rf_raddr_a_o;
  assign rd_b_en   = |rf_raddr_b_o;
  assign wait_done = (cnt_q == 3'd0);

  always_comb begin
    state_d      = state_q;
    op_ready_o   = 1'b0;
    wb_ready_o   = 1'b0;
    opnd_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // readies are gated so every output reads 0 while in reset
        wb_ready_o = rst_ni;
        op_ready_o = rst_ni & ~wb_valid_i;
        if (wb_valid_i)      state_d = WR_SETUP;
        else if (op_valid_i) state_d = RD_SETUP;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = IDLE;
      RD_SETUP: begin
        if (rd_a_en || rd_b_en) state_d = RD_PULSE;
        else                    state_d = RESP;
      end
      RD_PULSE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (wait_done) state_d = RESP;
      end
      RESP: begin
        opnd_valid_o = 1'b1;
        if (opnd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_hs = wb_valid_i & wb_ready_o;
  assign op_hs = op_valid_i & op_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_req_ra_o  <= 1'b0;
      rf_req_rb_o  <= 1'b0;
      rf_req_w_o   <= 1'b0;
      rf_raddr_a_o <= '0;
      rf_raddr_b_o <= '0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      rs1_data_o   <= '0;
      rs2_data_o   <= '0;
      cnt_q        <= '0;
    end else begin
      rf_req_ra_o <= 1'b0;
      rf_req_rb_o <= 1'b0;
      rf_req_w_o  <= 1'b0;
      if (wb_hs) begin
        rf_waddr_o <= wb_addr_i;
        rf_wdata_o <= wb_data_i;
      end
      if (op_hs) begin
        rf_raddr_a_o <= rs1_addr_i;
        rf_raddr_b_o <= rs2_addr_i;
      end
      if (state_q == WR_SETUP) rf_req_w_o <= |rf_waddr_o;
      if (state_q == RD_SETUP) begin
        rf_req_ra_o <= rd_a_en;
        rf_req_rb_o <= rd_b_en;
        if (!rd_a_en && !rd_b_en) begin
          rs1_data_o <= '0;
          rs2_data_o <= '0;
        end
      end
      if (state_q == RD_PULSE) begin
        cnt_q <= 3'(RfLatency - 1);
      end else if (state_q == RD_WAIT) begin
        if (!wait_done) begin
          cnt_q <= cnt_q - 3'd1;
        end else begin
          rs1_data_o <= rd_a_en ? rf_rdata_a_i : '0;
          rs2_data_o <= rd_b_en ? rf_rdata_b_i : '0;
        end
      end
    end
  end

`ifdef REGFILE_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (op_hs) rd_count_o <= rd_count_o + 32'd1;
      if (wb_hs) wr_count_o <= wr_count_o + 32'd1;
    end
  end
`endif

endmodule
